// File: rtl/ham_rx_ctrl.sv
// Hamming(7,4) receive controller: corrects single-bit errors, pairs nibbles into
// bytes with a ready/valid output stage, and tracks corrected-codeword statistics per frame.
module ham_rx_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       enc_ham_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       last_pos_error
);

    localparam int BC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LO    = 2'd1,
        HI    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state;
    logic [BC_W-1:0] byte_cnt;
    logic [3:0]      low_nib;
    logic [2:0]      syn;
    logic [3:0]      nib;
    logic            xfer;

    // Syndrome value equals the 1-based position of a single flipped bit.
    function automatic logic [2:0] syndrome(input logic [6:0] b);
        return {b[3] ^ b[4] ^ b[5] ^ b[6],
                b[1] ^ b[2] ^ b[5] ^ b[6],
                b[0] ^ b[2] ^ b[4] ^ b[6]};
    endfunction

    function automatic logic [3:0] correct_nibble(input logic [6:0] b, input logic [2:0] s);
        logic [6:0] c;
        c = b;
        if (s != 3'd0)
            c = b ^ (7'd1 << (s - 3'd1));
        return {c[6], c[5], c[4], c[2]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_comb begin
        syn = syndrome(enc_ham_data);
        nib = correct_nibble(enc_ham_data, syn);
        case (state)
            LO:      in_ready = 1'b1;
            HI:      in_ready = !out_valid || out_ready;
            default: in_ready = 1'b0;
        endcase
        xfer = in_valid && in_ready;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            byte_cnt       <= '0;
            low_nib        <= '0;
            out_valid      <= 1'b0;
            out_byte       <= '0;
            done           <= 1'b0;
            err_count      <= '0;
            last_pos_error <= '0;
        end else begin
            done <= 1'b0;
            // A fresh load in HI below overrides this clear, so back-to-back bytes have no bubble.
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (xfer && (syn != 3'd0)) begin
                err_count      <= sat_inc(err_count);
                last_pos_error <= syn;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        err_count      <= '0;
                        last_pos_error <= '0;
                        byte_cnt       <= '0;
                        state          <= LO;
                    end
                end
                LO: begin
                    if (xfer) begin
                        low_nib <= nib;
                        state   <= HI;
                    end
                end
                HI: begin
                    if (xfer) begin
                        out_byte  <= {nib, low_nib};
                        out_valid <= 1'b1;
                        byte_cnt  <= byte_cnt + 1'b1;
                        state     <= (byte_cnt == LAST_IDX) ? DRAIN : LO;
                    end
                end
                DRAIN: begin
                    if (!out_valid) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ham_rx_ctrl.sv
// Scoreboard bench for ham_rx_ctrl: one instance with FRAME_LEN=1/CNT_W=8 and one
// with FRAME_LEN=3/CNT_W=2, driven by hand-encoded codeword vectors.
module tb_ham_rx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_v, start_v, in_valid_v, ordy_v;
    logic [1:0][6:0] enc_v;
    wire  [1:0]      in_ready_v, ov_v, busy_v, done_v;
    wire  [1:0][7:0] ob_v;
    wire  [1:0][7:0] ec_v;
    wire  [1:0][2:0] lp_v;
    wire  [7:0]      ec0;
    wire  [1:0]      ec1;

    assign ec_v[0] = ec0;
    assign ec_v[1] = {6'd0, ec1};

    ham_rx_ctrl #(.FRAME_LEN(1), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_v[0]), .start(start_v[0]), .in_valid(in_valid_v[0]),
        .in_ready(in_ready_v[0]), .enc_ham_data(enc_v[0]), .out_valid(ov_v[0]),
        .out_ready(ordy_v[0]), .out_byte(ob_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .err_count(ec0), .last_pos_error(lp_v[0])
    );

    ham_rx_ctrl #(.FRAME_LEN(3), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_v[1]), .start(start_v[1]), .in_valid(in_valid_v[1]),
        .in_ready(in_ready_v[1]), .enc_ham_data(enc_v[1]), .out_valid(ov_v[1]),
        .out_ready(ordy_v[1]), .out_byte(ob_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .err_count(ec1), .last_pos_error(lp_v[1])
    );

    int n_pass  = 0;
    int n_total = 0;
    int rx[2];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input int d, input logic [7:0] b);
        if (d == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every handshaken byte is compared against the next expected one.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_v[d] && ov_v[d] && ordy_v[d]) begin
                rx[d]++;
                if (d == 0) begin
                    if (q0.size() == 0) chk("unexpected_byte0", {24'd0, ob_v[0]}, 32'hFFFF_FFFF);
                    else                chk("out_byte0", {24'd0, ob_v[0]}, {24'd0, q0.pop_front()});
                end else begin
                    if (q1.size() == 0) chk("unexpected_byte1", {24'd0, ob_v[1]}, 32'hFFFF_FFFF);
                    else                chk("out_byte1", {24'd0, ob_v[1]}, {24'd0, q1.pop_front()});
                end
            end
        end
    end

    task automatic start_frame(input int d);
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
    endtask

    task automatic send(input int d, input logic [6:0] cw);
        bit acc = 0;
        int n = 0;
        in_valid_v[d] = 1'b1;
        enc_v[d]      = cw;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready_v[d];
            tick();
            n++;
        end
        in_valid_v[d] = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_done(input int d);
        bit hs = 0;
        int n = 0;
        while (!hs && n < 40) begin
            @(negedge clk);
            hs = ov_v[d] && ordy_v[d];
            n++;
        end
        if (!hs) chk("last_handshake_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("done_early", {31'd0, done_v[d]}, 32'd0);
        chk("ov_after_hs", {31'd0, ov_v[d]}, 32'd0);
        @(negedge clk);
        chk("done_pulse", {31'd0, done_v[d]}, 32'd1);
        @(negedge clk);
        chk("done_width", {31'd0, done_v[d]}, 32'd0);
        chk("busy_idle", {31'd0, busy_v[d]}, 32'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rx[0] = 0;
        rx[1] = 0;
        rst_v      = 2'b00;
        start_v    = 2'b11;
        in_valid_v = 2'b11;
        enc_v[0]   = 7'h52;
        enc_v[1]   = 7'h52;
        ordy_v     = 2'b11;
        repeat (3) tick();

        // Reset state, with start/in_valid held high while in reset
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready_v[0]}, 32'd0);
        chk("rst_out_valid", {31'd0, ov_v[0]}, 32'd0);
        chk("rst_out_byte", {24'd0, ob_v[0]}, 32'd0);
        chk("rst_busy", {31'd0, busy_v[0]}, 32'd0);
        chk("rst_done", {31'd0, done_v[0]}, 32'd0);
        chk("rst_err_count", {24'd0, ec_v[0]}, 32'd0);
        chk("rst_last_pos", {29'd0, lp_v[0]}, 32'd0);
        chk("rst_busy1", {31'd0, busy_v[1]}, 32'd0);
        tick();
        start_v    = 2'b00;
        in_valid_v = 2'b00;
        rst_v      = 2'b11;
        @(negedge clk);
        chk("post_rst_idle0", {31'd0, busy_v[0]}, 32'd0);
        chk("post_rst_idle1", {31'd0, busy_v[1]}, 32'd0);
        tick();

        // Clean frame: 0x52 (A) + 0x2D (5) -> 0x5A
        start_frame(0);
        @(negedge clk);
        chk("busy_after_start", {31'd0, busy_v[0]}, 32'd1);
        chk("in_ready_lo", {31'd0, in_ready_v[0]}, 32'd1);
        tick();
        push(0, 8'h5A);
        send(0, 7'h52);
        send(0, 7'h2D);
        expect_done(0);
        chk("clean_err_count", {24'd0, ec_v[0]}, 32'd0);

        // Data-bit error (bit 4), plus a start pulse mid-frame that must be ignored
        start_frame(0);
        push(0, 8'h5A);
        send(0, 7'h42);
        @(negedge clk);
        chk("d_err_count", {24'd0, ec_v[0]}, 32'd1);
        chk("d_last_pos", {29'd0, lp_v[0]}, 32'd5);
        tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("start_ignored_busy", {31'd0, busy_v[0]}, 32'd1);
        chk("start_ignored_cnt", {24'd0, ec_v[0]}, 32'd1);
        tick();
        send(0, 7'h2D);
        expect_done(0);
        repeat (3) tick();
        @(negedge clk);
        chk("hold_err_count", {24'd0, ec_v[0]}, 32'd1);
        chk("hold_last_pos", {29'd0, lp_v[0]}, 32'd5);
        tick();

        // Parity-bit error (bit 0); start clears the previous statistics
        start_frame(0);
        @(negedge clk);
        chk("start_clears_cnt", {24'd0, ec_v[0]}, 32'd0);
        chk("start_clears_pos", {29'd0, lp_v[0]}, 32'd0);
        tick();
        push(0, 8'h5A);
        send(0, 7'h53);
        send(0, 7'h2D);
        expect_done(0);
        chk("p_err_count", {24'd0, ec_v[0]}, 32'd1);
        chk("p_last_pos", {29'd0, lp_v[0]}, 32'd1);

        // Backpressure on the 3-byte instance: bytes 0x5A, 0xC3, 0xF0
        ordy_v[1] = 1'b0;
        start_frame(1);
        push(1, 8'h5A);
        push(1, 8'hC3);
        push(1, 8'hF0);
        send(1, 7'h52);
        send(1, 7'h2D);
        send(1, 7'h1E);
        in_valid_v[1] = 1'b1;
        enc_v[1]      = 7'h61;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, ov_v[1]}, 32'd1);
            chk("bp_out_byte", {24'd0, ob_v[1]}, 32'h5A);
            chk("bp_in_ready_hi", {31'd0, in_ready_v[1]}, 32'd0);
            tick();
        end
        ordy_v[1] = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'd0, in_ready_v[1]}, 32'd1);
        tick();
        in_valid_v[1] = 1'b0;
        @(negedge clk);
        chk("bp_no_bubble_valid", {31'd0, ov_v[1]}, 32'd1);
        chk("bp_no_bubble_byte", {24'd0, ob_v[1]}, 32'hC3);
        tick();
        send(1, 7'h00);
        send(1, 7'h7F);
        expect_done(1);
        chk("bp_bytes_received", rx[1], 32'd3);

        // Saturation: five erroneous codewords into a 2-bit counter
        start_frame(1);
        push(1, 8'h5A);
        push(1, 8'hC3);
        push(1, 8'hF0);
        send(1, 7'h53);
        send(1, 7'h6D);
        send(1, 7'h1A);
        @(negedge clk);
        chk("sat_reach", {24'd0, ec_v[1]}, 32'd3);
        chk("sat_pos3", {29'd0, lp_v[1]}, 32'd3);
        tick();
        send(1, 7'h69);
        @(negedge clk);
        chk("sat_hold", {24'd0, ec_v[1]}, 32'd3);
        chk("sat_pos4", {29'd0, lp_v[1]}, 32'd4);
        tick();
        send(1, 7'h00);
        send(1, 7'h5F);
        expect_done(1);
        chk("sat_err_count", {24'd0, ec_v[1]}, 32'd3);
        chk("sat_last_pos", {29'd0, lp_v[1]}, 32'd6);
        chk("sat_bytes_received", rx[1], 32'd6);

        // Reset mid-frame while in HI with a byte pending
        ordy_v[1] = 1'b0;
        start_frame(1);
        send(1, 7'h53);
        send(1, 7'h2D);
        send(1, 7'h1E);
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, ov_v[1]}, 32'd1);
        chk("pre_rst_err", {24'd0, ec_v[1]}, 32'd1);
        rst_v[1]      = 1'b0;
        start_v[1]    = 1'b1;
        in_valid_v[1] = 1'b1;
        enc_v[1]      = 7'h42;
        #1;
        chk("mrst_in_ready", {31'd0, in_ready_v[1]}, 32'd0);
        chk("mrst_out_valid", {31'd0, ov_v[1]}, 32'd0);
        chk("mrst_out_byte", {24'd0, ob_v[1]}, 32'd0);
        chk("mrst_busy", {31'd0, busy_v[1]}, 32'd0);
        chk("mrst_done", {31'd0, done_v[1]}, 32'd0);
        chk("mrst_err_count", {24'd0, ec_v[1]}, 32'd0);
        chk("mrst_last_pos", {29'd0, lp_v[1]}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        chk("mrst_start_ignored", {31'd0, busy_v[1]}, 32'd0);
        tick();
        start_v[1]    = 1'b0;
        in_valid_v[1] = 1'b0;
        rst_v[1]      = 1'b1;
        ordy_v[1]     = 1'b1;
        tick();
        start_frame(1);
        push(1, 8'h5C);
        push(1, 8'hF0);
        push(1, 8'h5A);
        send(1, 7'h61);
        send(1, 7'h2D);
        send(1, 7'h00);
        send(1, 7'h7F);
        send(1, 7'h52);
        send(1, 7'h2D);
        expect_done(1);
        chk("after_rst_err_count", {24'd0, ec_v[1]}, 32'd0);

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
